// File: rtl/part_ls299_bus_reg.sv
`default_nettype none
// ============================================================================
// Module      : part_ls299_bus_reg
// Description : Universal shift/storage register for the receiving and
//               driving end of a shared tri-state data bus. It captures bus
//               data, holds it, shifts it serially in either direction and
//               presents the stored value back to the bus pads.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK         in   1      rising-edge clock
//   ASYN_CLR_N  in   1      asynchronous active-low clear of the register
//   CLK_ENB_N   in   1      active-low clock enable (high = hold)
//   S0, S1      in   1      mode select {S1,S0}: 00 hold, 01 shift right,
//                           10 shift left, 11 parallel load
//   OE1_N/OE2_N in   1      active-low output enables
//   DSR         in   1      serial data entering bit 0 on shift right
//   DSL         in   1      serial data entering bit WIDTH-1 on shift left
//   BUS_IN      in   WIDTH  bus value captured on parallel load
//   BUS_OUT     out  WIDTH  register contents for the bus pads
//   BUS_OE      out  1      high when BUS_OUT should be driven on the bus
//   Q0S         out  1      register bit 0
//   Q7S         out  1      register bit WIDTH-1
// ============================================================================
module part_ls299_bus_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYN_CLR_N,
  input  logic             CLK_ENB_N,
  input  logic             S0,
  input  logic             S1,
  input  logic             OE1_N,
  input  logic             OE2_N,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [WIDTH-1:0] BUS_IN,
  output logic [WIDTH-1:0] BUS_OUT,
  output logic             BUS_OE,
  output logic             Q0S,
  output logic             Q7S
);

  localparam logic [1:0] C_MODE_HOLD  = 2'b00;
  localparam logic [1:0] C_MODE_SHR   = 2'b01;
  localparam logic [1:0] C_MODE_SHL   = 2'b10;
  localparam logic [1:0] C_MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] r_data;
  logic [1:0]       w_mode;

  assign w_mode = {S1, S0};

  always_ff @(posedge CLK or negedge ASYN_CLR_N) begin
    if (!ASYN_CLR_N) begin
      r_data <= '0;
    end else if (!CLK_ENB_N) begin
      case (w_mode)
        C_MODE_HOLD: r_data <= r_data;
        C_MODE_SHR:  r_data <= {r_data[WIDTH-2:0], DSR};
        C_MODE_SHL:  r_data <= {DSL, r_data[WIDTH-1:1]};
        C_MODE_LOAD: r_data <= BUS_IN;
        // An unknown mode select must not silently resolve to a legal mode;
        // propagating X makes the fault visible in simulation.
        default:     r_data <= 'x;
      endcase
    end
  end

  assign BUS_OUT = r_data;
  assign Q0S     = r_data[0];
  assign Q7S     = r_data[WIDTH-1];

  // Never drive the bus while loading so the source owns it during capture.
  // Reset does not gate the enable.
  assign BUS_OE  = ~OE1_N & ~OE2_N & ~(S1 & S0);

endmodule
`default_nettype wire

// File: tb/tb_part_ls299_bus_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_part_ls299_bus_reg
// Description : Self-checking bench for part_ls299_bus_reg. Directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_part_ls299_bus_reg;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             ASYN_CLR_N;
  logic             CLK_ENB_N;
  logic             S0, S1;
  logic             OE1_N, OE2_N;
  logic             DSR, DSL;
  logic [WIDTH-1:0] BUS_IN;
  logic [WIDTH-1:0] BUS_OUT;
  logic             BUS_OE;
  logic             Q0S, Q7S;

  int checks = 0;
  int errors = 0;

  // Model state: the register value as an unsigned integer.
  int unsigned model_r;

  part_ls299_bus_reg #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .ASYN_CLR_N (ASYN_CLR_N),
    .CLK_ENB_N  (CLK_ENB_N),
    .S0         (S0),
    .S1         (S1),
    .OE1_N      (OE1_N),
    .OE2_N      (OE2_N),
    .DSR        (DSR),
    .DSL        (DSL),
    .BUS_IN     (BUS_IN),
    .BUS_OUT    (BUS_OUT),
    .BUS_OE     (BUS_OE),
    .Q0S        (Q0S),
    .Q7S        (Q7S)
  );

  always #5 CLK = ~CLK;

  localparam int unsigned MASK = (1 << WIDTH) - 1;

  // Register value after one enabled edge, from the data-sheet rules:
  // "right" moves data toward the MSB with DSR entering at the bottom,
  // "left" moves toward the LSB with DSL entering at the top.
  function automatic int unsigned model_next(int unsigned r);
    if (!ASYN_CLR_N) return 0;
    if (CLK_ENB_N) return r;
    if (S1 && S0) return BUS_IN;
    if (!S1 && S0) return ((r * 2) + DSR) & MASK;
    if (S1 && !S0) return (r / 2) + (DSL ? (1 << (WIDTH - 1)) : 0);
    return r;
  endfunction

  function automatic logic model_oe();
    return (OE1_N == 1'b0) && (OE2_N == 1'b0) && !(S1 == 1'b1 && S0 == 1'b1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bus_out"}, 32'(BUS_OUT), 32'(model_r));
    check({tag, ".q0s"},     32'(Q0S),     32'(model_r & 1));
    check({tag, ".q7s"},     32'(Q7S),     32'((model_r >> (WIDTH - 1)) & 1));
    check({tag, ".bus_oe"},  32'(BUS_OE),  32'(model_oe()));
  endtask

  // Apply current inputs at the next rising edge, then sample 1 time unit later.
  task automatic tick();
    model_r = model_next(model_r);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_mode(input logic s1, input logic s0);
    S1 = s1;
    S0 = s0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    set_mode(1'b1, 1'b1);
    CLK_ENB_N = 1'b0;
    BUS_IN = v;
    tick();
  endtask

  initial begin
    ASYN_CLR_N = 1'b0; CLK_ENB_N = 1'b1; S0 = 1'b0; S1 = 1'b0;
    OE1_N = 1'b0; OE2_N = 1'b0; DSR = 1'b0; DSL = 1'b0; BUS_IN = '0;
    model_r = 0;
    #2;
    check_all("reset_state");
    @(posedge CLK); #1;
    ASYN_CLR_N = 1'b1;

    // Async clear between edges.
    load(8'hA5);
    check_all("load_a5");
    set_mode(1'b0, 1'b0);
    #1;
    ASYN_CLR_N = 1'b0;
    model_r = 0;
    #1;
    check_all("async_clear_immediate");
    set_mode(1'b1, 1'b1); CLK_ENB_N = 1'b0; BUS_IN = 8'hFF;
    tick();
    check_all("clear_held_over_load");
    set_mode(1'b0, 1'b0);
    #1;
    check("oe_not_forced_by_reset", 32'(BUS_OE), 32'(1));
    ASYN_CLR_N = 1'b1;

    // Parallel load, BUS_OE low during load mode.
    load(8'h3C);
    check_all("load_3c");
    check("oe_off_in_load", 32'(BUS_OE), 32'(0));
    set_mode(1'b0, 1'b0);
    #1;
    check("oe_on_in_hold", 32'(BUS_OE), 32'(1));

    // Shift right from 0x81 with DSR=0.
    load(8'h81);
    check("q7s_before_shr", 32'(Q7S), 32'(1));
    set_mode(1'b0, 1'b1); DSR = 1'b0;
    tick();
    check_all("shr_1");
    tick();
    check_all("shr_2");
    check("shr_result_04", 32'(BUS_OUT), 32'h04);

    // Shift left with Q0S recirculated into DSL.
    load(8'h01);
    set_mode(1'b1, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      DSL = model_r[0];
      tick();
      check_all("shl_recirc");
    end
    check("shl_recirc_back_to_01", 32'(BUS_OUT), 32'h01);

    // Clock enable and hold.
    load(8'h5A);
    CLK_ENB_N = 1'b1; set_mode(1'b1, 1'b1); BUS_IN = 8'hFF;
    tick();
    check_all("enable_off_hold");
    CLK_ENB_N = 1'b0; set_mode(1'b0, 1'b0);
    tick();
    check_all("mode_hold");
    check("hold_value_5a", 32'(BUS_OUT), 32'h5A);

    // OE1_N high disables the bus in every mode.
    OE1_N = 1'b1;
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      #1;
      check("oe1_high_disables", 32'(BUS_OE), 32'(0));
    end
    OE1_N = 1'b0;

    // Reset falling at the same edge as a load of 0xFF.
    set_mode(1'b1, 1'b1); BUS_IN = 8'hFF; CLK_ENB_N = 1'b0;
    @(negedge CLK);
    #5;
    ASYN_CLR_N = 1'b0;
    model_r = 0;
    #1;
    check_all("race_reset_wins");
    ASYN_CLR_N = 1'b1;

    // Randomized traffic with occasional mid-sequence resets.
    for (int n = 0; n < 300; n++) begin
      {S1, S0}  = 2'($urandom_range(0, 3));
      CLK_ENB_N = ($urandom_range(0, 7) == 0);
      OE1_N     = ($urandom_range(0, 3) == 0);
      OE2_N     = ($urandom_range(0, 3) == 0);
      DSR       = 1'($urandom);
      DSL       = 1'($urandom);
      BUS_IN    = WIDTH'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        ASYN_CLR_N = 1'b0;
        model_r = 0;
        #1;
        check_all("rand_async_clear");
        ASYN_CLR_N = 1'b1;
      end
      tick();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
